// File: rtl/packed_pkg.sv
// Shared constants and types for the packed switch network input loader.
package packed_pkg;

    localparam int DATA_WIDTH = 512;
    localparam int PORT_NUM   = 32;
    localparam int SWITCH_NUM = PORT_NUM / 2;
    localparam int CNT_W      = $clog2(PORT_NUM);

    typedef logic [DATA_WIDTH-1:0]  port_word_t;
    typedef port_word_t [0:PORT_NUM-1] frame_t;
    typedef logic [0:SWITCH_NUM-1]  switch_set_t;

endpackage

// File: rtl/packed_frame_bank.sv
// One frame buffer of the ping-pong pair: indexed word write, switch-setting
// capture on beat 0, zero-fill of the unused tail when a frame closes early,
// and the full/short flags describing the stored frame.
module packed_frame_bank
    import packed_pkg::*;
#(
    parameter int DATA_WIDTH = packed_pkg::DATA_WIDTH,
    parameter int PORT_NUM   = packed_pkg::PORT_NUM,
    parameter int SWITCH_NUM = PORT_NUM / 2,
    parameter int CNT_W      = $clog2(PORT_NUM)
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic                                  i_wr_en,
    input  logic [CNT_W-1:0]                      i_idx,
    input  logic [DATA_WIDTH-1:0]                 i_data,
    input  logic [0:SWITCH_NUM-1]                 i_switch_set,
    input  logic                                  i_close,
    input  logic                                  i_release,
    output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]   o_port,
    output logic [0:SWITCH_NUM-1]                 o_switch_set,
    output logic                                  o_short,
    output logic                                  o_full
);

    logic [0:PORT_NUM-1][DATA_WIDTH-1:0] r_port;
    logic [0:SWITCH_NUM-1]               r_switch_set;
    logic                                r_short;
    logic                                r_full;

    // Word storage: the addressed port takes the beat; on an early close every
    // port above it is cleared so stale words never leak into a short frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_port <= '0;
        end else if (i_wr_en) begin
            for (int k = 0; k < PORT_NUM; k++) begin
                if (k == int'(i_idx)) begin
                    r_port[k] <= i_data;
                end else if (i_close && (k > int'(i_idx))) begin
                    r_port[k] <= '0;
                end
            end
        end
    end

    // The switch setting belongs to the frame and is taken from its first beat.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_switch_set <= '0;
        end else if (i_wr_en && (i_idx == '0)) begin
            r_switch_set <= i_switch_set;
        end
    end

    // Frame status: full from close until the consumer releases it; short when
    // the closing beat was not the last port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_full  <= 1'b0;
            r_short <= 1'b0;
        end else if (i_wr_en && i_close) begin
            r_full  <= 1'b1;
            r_short <= (i_idx != CNT_W'(PORT_NUM - 1));
        end else if (i_release) begin
            r_full  <= 1'b0;
        end
    end

    assign o_port       = r_port;
    assign o_switch_set = r_switch_set;
    assign o_short      = r_short;
    assign o_full       = r_full;

endmodule

// File: rtl/packed_frame_loader.sv
// Input-side loader: gathers PORT_NUM stream beats into a parallel frame,
// double-buffered so one bank fills while the other waits for the consumer.
module packed_frame_loader
    import packed_pkg::*;
#(
    parameter int DATA_WIDTH = packed_pkg::DATA_WIDTH,
    parameter int PORT_NUM   = packed_pkg::PORT_NUM,
    parameter int SWITCH_NUM = PORT_NUM / 2,
    parameter int CNT_W      = $clog2(PORT_NUM)
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic                                  I_VALID,
    output logic                                  I_READY,
    input  logic [DATA_WIDTH-1:0]                 I_DATA,
    input  logic                                  I_LAST,
    input  logic [0:SWITCH_NUM-1]                 I_SWITCH_SET,
    output logic                                  O_VALID,
    input  logic                                  O_READY,
    output logic [0:PORT_NUM-1][DATA_WIDTH-1:0]   O_PORT,
    output logic [0:SWITCH_NUM-1]                 O_SWITCH_SET,
    output logic                                  O_SHORT
);

    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic                                w_ready;
    logic                                w_accept;
    logic                                w_close;
    logic                                w_release;
    logic [1:0]                          w_full;
    logic [1:0]                          w_short;
    logic [0:PORT_NUM-1][DATA_WIDTH-1:0] w_port       [2];
    logic [0:SWITCH_NUM-1]               w_switch_set [2];

    // Ready depends only on registered flags, so a release frees the bank one
    // cycle before the producer sees it.
    assign w_ready   = !w_full[r_wr_ptr];
    assign w_accept  = I_VALID && w_ready;
    assign w_close   = w_accept && (I_LAST || (r_cnt == CNT_W'(PORT_NUM - 1)));
    assign w_release = w_full[r_rd_ptr] && O_READY;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            packed_frame_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .PORT_NUM   (PORT_NUM),
                .SWITCH_NUM (SWITCH_NUM),
                .CNT_W      (CNT_W)
            ) u_bank (
                .CLK          (CLK),
                .RST_N        (RST_N),
                .i_wr_en      (w_accept && (r_wr_ptr == 1'(b))),
                .i_idx        (r_cnt),
                .i_data       (I_DATA),
                .i_switch_set (I_SWITCH_SET),
                .i_close      (w_close),
                .i_release    (w_release && (r_rd_ptr == 1'(b))),
                .o_port       (w_port[b]),
                .o_switch_set (w_switch_set[b]),
                .o_short      (w_short[b]),
                .o_full       (w_full[b])
            );
        end
    endgenerate

    // Write side: beat counter advances per accepted beat and wraps to the
    // other bank when a frame closes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_wr_ptr <= 1'b0;
        end else if (w_close) begin
            r_cnt    <= '0;
            r_wr_ptr <= !r_wr_ptr;
        end else if (w_accept) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Read side: move to the other bank once the consumer takes a frame.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_ptr <= 1'b0;
        end else if (w_release) begin
            r_rd_ptr <= !r_rd_ptr;
        end
    end

    assign I_READY      = w_ready;
    assign O_VALID      = w_full[r_rd_ptr];
    assign O_PORT       = w_port[r_rd_ptr];
    assign O_SWITCH_SET = w_switch_set[r_rd_ptr];
    assign O_SHORT      = w_short[r_rd_ptr];

endmodule
